gnn_0_example_bias_bank_loader: RTL and testbench
=================================================

Name: gnn_0_example_bias_bank_loader

Overview:
- Multi-bank successor of the single-buffer bias loader.
- Decodes one 96-bit load instruction and drives the AXI read master control port (start/addr/size).
- Accepts the returned AXI4-Stream beats with real back-pressure and writes them into one of NUM_BANKS on-chip bias banks, wrapping addresses at bank depth.
- Sits between the instruction controller and the bias buffer banks feeding the GNN compute array.

Parameters:
- C_M_AXI_ADDR_WIDTH, 64, DRAM byte-address width.
- C_M_AXI_DATA_WIDTH, 512, stream beat and buffer word width.
- C_XFER_SIZE_WIDTH, 32, transfer-size width to the read master.
- BIAS_INST_LENGTH, 96, instruction width.
- NUM_BANKS, 4, number of bias banks (1..16).
- BUF_ADDR_WIDTH, 9, bank address width; depth = 2**BUF_ADDR_WIDTH.

Ports:
- kernel_clk  in  1  sole clock.
- kernel_rst_n  in  1  asynchronous, active-low reset.
- ap_start  in  1  instruction valid; sampled only in IDLE.
- ap_done  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- ctrl_addr_offset  in  C_M_AXI_ADDR_WIDTH  DRAM base address.
- ctrl_instruction  in  BIAS_INST_LENGTH  load instruction.
- rd_start  out  1  one-cycle start pulse to the read master.
- rd_done  in  1  read-master completion pulse.
- rd_addr  out  C_M_AXI_ADDR_WIDTH  transfer start address.
- rd_size  out  C_XFER_SIZE_WIDTH  transfer size in bytes.
- s_tvalid  in  1  stream beat valid.
- s_tready  out  1  stream beat ready.
- s_tlast  in  1  stream last beat.
- s_tdata  in  C_M_AXI_DATA_WIDTH  stream data.
- buf_wr_valid  out  NUM_BANKS  one-hot bank write enable.
- buf_wr_addr  out  BUF_ADDR_WIDTH  write address (shared by all banks).
- buf_wr_data  out  C_M_AXI_DATA_WIDTH  write data (shared by all banks).

Behaviour:
- Clock and reset: one clock, kernel_clk; kernel_rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; all counters 0.
- Instruction fields:
  - bank_sel = inst[27:24]
  - buf_start = inst[47:32]
  - beat_len = inst[63:48]
  - dram_start = inst[79:64]
  - byte_len = inst[95:80]
- Address and size arithmetic:
  - rd_addr = ctrl_addr_offset + zero-extended dram_start.
  - rd_size = zero-extended byte_len.
- FSM states:
  - IDLE: ap_start=1 latches all fields -> DECODE.
  - DECODE: beat_len==0 -> DONE, no read issued. Otherwise -> ISSUE.
  - ISSUE: rd_start=1 for exactly 1 cycle -> STREAM.
  - STREAM: handshake = s_tvalid & s_tready.
    - s_tready=1 throughout STREAM.
    - Beats with count < beat_len are written; later beats are accepted and discarded (drain).
    - Exit to DONE when count==beat_len and rd_done has been seen (sticky flag, may arrive in any order).
  - DONE: ap_done=1 for 1 cycle -> IDLE.
- Write timing: registered; a handshake in cycle n produces the write in cycle n+1.
  - buf_wr_addr = (buf_start + count) mod 2**BUF_ADDR_WIDTH; upper bits of buf_start are ignored and the address wraps.
  - buf_wr_valid[bank_sel] = 1; all other bits 0.
  - bank_sel >= NUM_BANKS: all writes masked, the transfer still drains and completes.
- Latency:
  - ap_start at cycle 0 -> rd_start at cycle 2.
  - Zero-length instruction -> ap_done at cycle 2.
  - Final write at cycle n -> ap_done at max(n+1, rd_done+1).
- Boundary conditions:
  - ap_start while busy: ignored, with no queueing.
  - s_tlast is not used for termination.
  - Reset mid-transfer: immediate return to IDLE with outputs cleared. The read master is reset by the same net.
  - beat_len > bank depth: addresses wrap and earlier words are overwritten.

Optional Feature:
- Macro: BIAS_BANK_LOADER_CHECK_EN.
- When defined, two extra outputs are added: err (1 bit, sticky until the next accepted ap_start) and err_code (2 bits).
  - 01: bank_sel out of range.
  - 10: s_tlast seen before beat beat_len.
  - 11: beats dropped during drain.
  - On multiple errors, the first one wins.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package gnn_0_example_bias_pkg holds:
  - the state enum type;
  - a packed struct for the instruction fields;
  - field-position localparams;
  - err_code constants.
- One sub-module, gnn_0_example_bias_bank_wr: registered write stage with address wrap, one-hot bank decode and masking.

Test Plan:
- Basic load: bank 2, buf_start=10, beat_len=4, byte_len=256, 4 beats -> buf_wr_valid=4'b0100 at addresses 10..13 with data in order; ap_done 1 cycle after rd_done.
- Wrap-around: buf_start=510, beat_len=4 -> addresses 510, 511, 0, 1.
- Zero length: beat_len=0 -> rd_start never asserted; ap_done at cycle 2; no writes.
- Drain and order: 6 beats delivered for beat_len=4 -> 4 writes, 2 beats dropped; rd_done arriving before the last beat still yields exactly one ap_done. With CHECK_EN, err_code=11.
- Bad bank: bank_sel=7 with NUM_BANKS=4 -> no buf_wr_valid bits set, ap_done pulses; with CHECK_EN, err_code=01.
- Reset mid-stream: kernel_rst_n low after beat 2 -> all outputs 0 asynchronously; a new instruction afterwards completes normally; ap_start while busy is ignored.

Source files
------------

// File: rtl/gnn_0_example_bias_pkg.sv
// Shared types and constants for the bias bank loader: FSM states, instruction layout, error codes.
package gnn_0_example_bias_pkg;

    localparam int unsigned INST_W     = 96;
    localparam int unsigned FIELD_W    = 16;
    localparam int unsigned BANK_SEL_W = 4;

    // Bit positions of the instruction fields
    localparam int unsigned BANK_SEL_LSB   = 24;
    localparam int unsigned BUF_START_LSB  = 32;
    localparam int unsigned BEAT_LEN_LSB   = 48;
    localparam int unsigned DRAM_START_LSB = 64;
    localparam int unsigned BYTE_LEN_LSB   = 80;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_BANK       = 2'b01;
    localparam logic [1:0] ERR_EARLY_LAST = 2'b10;
    localparam logic [1:0] ERR_DRAIN      = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ISSUE,
        ST_STREAM,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [FIELD_W-1:0]    byte_len;
        logic [FIELD_W-1:0]    dram_start;
        logic [FIELD_W-1:0]    beat_len;
        logic [FIELD_W-1:0]    buf_start;
        logic [3:0]            rsvd_hi;
        logic [BANK_SEL_W-1:0] bank_sel;
        logic [23:0]           rsvd_lo;
    } bias_inst_t;

endpackage

// File: rtl/gnn_0_example_bias_bank_loader_if.sv
// Read-master control, AXI4-Stream beat and bias-bank write signals of the loader.
interface gnn_0_example_bias_bank_loader_if #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned NUM_BANKS          = 4,
    parameter int unsigned BUF_ADDR_WIDTH     = 9
);
    logic                          rd_start;
    logic                          rd_done;
    logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr;
    logic [C_XFER_SIZE_WIDTH-1:0]  rd_size;
    logic                          s_tvalid;
    logic                          s_tready;
    logic                          s_tlast;
    logic [C_M_AXI_DATA_WIDTH-1:0] s_tdata;
    logic [NUM_BANKS-1:0]          buf_wr_valid;
    logic [BUF_ADDR_WIDTH-1:0]     buf_wr_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] buf_wr_data;

    modport master (
        output rd_start, rd_addr, rd_size, s_tready, buf_wr_valid, buf_wr_addr, buf_wr_data,
        input  rd_done, s_tvalid, s_tlast, s_tdata
    );

    modport slave (
        input  rd_start, rd_addr, rd_size, s_tready, buf_wr_valid, buf_wr_addr, buf_wr_data,
        output rd_done, s_tvalid, s_tlast, s_tdata
    );
endinterface

// File: rtl/gnn_0_example_bias_bank_wr.sv
// Registered bank write stage: wraps the address at bank depth and one-hot decodes the bank, masking invalid banks.
module gnn_0_example_bias_bank_wr
    import gnn_0_example_bias_pkg::*;
#(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
    parameter int unsigned NUM_BANKS          = 4,
    parameter int unsigned BUF_ADDR_WIDTH     = 9
) (
    input  logic                          kernel_clk,
    input  logic                          kernel_rst_n,
    input  logic                          wr_en,
    input  logic [BANK_SEL_W-1:0]         bank_sel,
    input  logic [BUF_ADDR_WIDTH-1:0]     base,
    input  logic [BUF_ADDR_WIDTH-1:0]     offset,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] data,
    output logic [NUM_BANKS-1:0]          wr_valid,
    output logic [BUF_ADDR_WIDTH-1:0]     wr_addr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] wr_data
);
    logic                 bank_ok_c;
    logic [NUM_BANKS-1:0] onehot_c;

    assign bank_ok_c = (32'(bank_sel) < NUM_BANKS);
    assign onehot_c  = bank_ok_c ? (NUM_BANKS'(1) << bank_sel) : '0;

    // Address sum is naturally modulo the bank depth
    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            wr_valid <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_valid <= wr_en ? onehot_c : '0;
            if (wr_en) begin
                wr_addr <= base + offset;
                wr_data <= data;
            end
        end
    end
endmodule

// File: rtl/gnn_0_example_bias_bank_loader.sv
// Bias bank loader: decodes a load instruction, launches the DRAM read and steers stream beats into one bias bank.
// Optional error reporting (err/err_code) is built when BIAS_BANK_LOADER_CHECK_EN is defined.
module gnn_0_example_bias_bank_loader
    import gnn_0_example_bias_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned BIAS_INST_LENGTH   = 96,
    parameter int unsigned NUM_BANKS          = 4,
    parameter int unsigned BUF_ADDR_WIDTH     = 9
) (
    input  logic                          kernel_clk,
    input  logic                          kernel_rst_n,
    input  logic                          ap_start,
    output logic                          ap_done,
    output logic                          busy,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [BIAS_INST_LENGTH-1:0]   ctrl_instruction,
`ifdef BIAS_BANK_LOADER_CHECK_EN
    output logic                          err,
    output logic [1:0]                    err_code,
`endif
    gnn_0_example_bias_bank_loader_if.master bus
);
    bias_inst_t                inst_c;
    state_t                    state_q, state_d;
    logic [BANK_SEL_W-1:0]     bank_sel_q;
    logic [BUF_ADDR_WIDTH-1:0] buf_start_q;
    logic [BUF_ADDR_WIDTH-1:0] offset_c;
    logic [FIELD_W-1:0]        beat_len_q;
    logic [FIELD_W-1:0]        count_q, count_d;
    logic                      done_seen_q, done_seen_d;
    logic                      rd_start_d, ap_done_d, busy_d, tready_d;
    logic                      accept_c, hs_c, wr_en_c;
    logic                      unused_c;

    assign inst_c   = bias_inst_t'(ctrl_instruction);
    assign accept_c = (state_q == ST_IDLE) && ap_start;
    assign hs_c     = bus.s_tvalid && bus.s_tready;
    assign wr_en_c  = hs_c && (count_q < beat_len_q);
    assign offset_c = BUF_ADDR_WIDTH'(count_q);
    assign unused_c = ^{inst_c.rsvd_hi, inst_c.rsvd_lo, bus.s_tlast};

    // Latch the instruction fields and read request when an instruction is accepted
    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            bank_sel_q  <= '0;
            buf_start_q <= '0;
            beat_len_q  <= '0;
            bus.rd_addr <= '0;
            bus.rd_size <= '0;
        end else if (accept_c) begin
            bank_sel_q  <= inst_c.bank_sel;
            buf_start_q <= BUF_ADDR_WIDTH'(inst_c.buf_start);
            beat_len_q  <= inst_c.beat_len;
            bus.rd_addr <= ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(inst_c.dram_start);
            bus.rd_size <= C_XFER_SIZE_WIDTH'(inst_c.byte_len);
        end
    end

    // Next state; rd_done is sticky so it may arrive before or after the final beat
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        done_seen_d = done_seen_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    state_d     = ST_DECODE;
                    count_d     = '0;
                    done_seen_d = 1'b0;
                end
            end
            ST_DECODE: state_d = (beat_len_q == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE:  state_d = ST_STREAM;
            ST_STREAM: begin
                if (wr_en_c)     count_d     = count_q + FIELD_W'(1);
                if (bus.rd_done) done_seen_d = 1'b1;
                if ((count_q == beat_len_q) && (done_seen_q || bus.rd_done)) state_d = ST_DONE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        rd_start_d = (state_d == ST_ISSUE);
        ap_done_d  = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
        tready_d   = (state_d == ST_STREAM);
    end

    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            done_seen_q  <= 1'b0;
            bus.rd_start <= 1'b0;
            ap_done      <= 1'b0;
            busy         <= 1'b0;
            bus.s_tready <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            done_seen_q  <= done_seen_d;
            bus.rd_start <= rd_start_d;
            ap_done      <= ap_done_d;
            busy         <= busy_d;
            bus.s_tready <= tready_d;
        end
    end

    gnn_0_example_bias_bank_wr #(
        .C_M_AXI_DATA_WIDTH(C_M_AXI_DATA_WIDTH),
        .NUM_BANKS         (NUM_BANKS),
        .BUF_ADDR_WIDTH    (BUF_ADDR_WIDTH)
    ) u_bank_wr (
        .kernel_clk  (kernel_clk),
        .kernel_rst_n(kernel_rst_n),
        .wr_en       (wr_en_c),
        .bank_sel    (bank_sel_q),
        .base        (buf_start_q),
        .offset      (offset_c),
        .data        (bus.s_tdata),
        .wr_valid    (bus.buf_wr_valid),
        .wr_addr     (bus.buf_wr_addr),
        .wr_data     (bus.buf_wr_data)
    );

`ifdef BIAS_BANK_LOADER_CHECK_EN
    logic bank_ok_c;
    assign bank_ok_c = (32'(bank_sel_q) < NUM_BANKS);

    // First error of a transfer is kept until the next accepted instruction
    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (accept_c) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (!err) begin
            if ((state_q == ST_DECODE) && !bank_ok_c) begin
                err      <= 1'b1;
                err_code <= ERR_BANK;
            end else if (wr_en_c && bus.s_tlast && ((count_q + FIELD_W'(1)) < beat_len_q)) begin
                err      <= 1'b1;
                err_code <= ERR_EARLY_LAST;
            end else if (hs_c && !wr_en_c) begin
                err      <= 1'b1;
                err_code <= ERR_DRAIN;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gnn_0_example_bias_bank_loader.sv
// Randomized directed bench for the bias bank loader; the testbench acts as read master and checks a queue-based model.
`timescale 1ns/1ps
module tb_gnn_0_example_bias_bank_loader;
    import gnn_0_example_bias_pkg::*;

    localparam int unsigned AW    = 64;
    localparam int unsigned DW    = 512;
    localparam int unsigned SW    = 32;
    localparam int unsigned IW    = 96;
    localparam int unsigned NB    = 4;
    localparam int unsigned BAW   = 9;
    localparam int unsigned DEPTH = 1 << BAW;

    logic          kernel_clk;
    logic          kernel_rst_n;
    logic          ap_start;
    logic          ap_done;
    logic          busy;
    logic [AW-1:0] ctrl_addr_offset;
    logic [IW-1:0] ctrl_instruction;
`ifdef BIAS_BANK_LOADER_CHECK_EN
    logic          err;
    logic [1:0]    err_code;
`endif

    int total;
    int bad;

    gnn_0_example_bias_bank_loader_if #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_XFER_SIZE_WIDTH(SW),
        .NUM_BANKS(NB), .BUF_ADDR_WIDTH(BAW)
    ) bus ();

    gnn_0_example_bias_bank_loader #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_XFER_SIZE_WIDTH(SW),
        .BIAS_INST_LENGTH(IW), .NUM_BANKS(NB), .BUF_ADDR_WIDTH(BAW)
    ) dut (
        .kernel_clk      (kernel_clk),
        .kernel_rst_n    (kernel_rst_n),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .busy            (busy),
        .ctrl_addr_offset(ctrl_addr_offset),
        .ctrl_instruction(ctrl_instruction),
`ifdef BIAS_BANK_LOADER_CHECK_EN
        .err             (err),
        .err_code        (err_code),
`endif
        .bus             (bus)
    );

    initial kernel_clk = 1'b0;
    always #5 kernel_clk = ~kernel_clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] make_inst(input logic [3:0] bank, input logic [15:0] bstart,
                                                input logic [15:0] blen, input logic [15:0] dram,
                                                input logic [15:0] bytes);
        logic [IW-1:0] r;
        r = '0;
        r[23:0]  = 24'($urandom);
        r[31:28] = 4'($urandom);
        r[BANK_SEL_LSB   +: BANK_SEL_W] = bank;
        r[BUF_START_LSB  +: FIELD_W]    = bstart;
        r[BEAT_LEN_LSB   +: FIELD_W]    = blen;
        r[DRAM_START_LSB +: FIELD_W]    = dram;
        r[BYTE_LEN_LSB   +: FIELD_W]    = bytes;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int j = 0; j < int'(DW / 32); j++) w[j*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".ap_done"},  DW'(ap_done),          DW'(0));
        chk({tag, ".busy"},     DW'(busy),             DW'(0));
        chk({tag, ".rd_start"}, DW'(bus.rd_start),     DW'(0));
        chk({tag, ".rd_addr"},  DW'(bus.rd_addr),      DW'(0));
        chk({tag, ".rd_size"},  DW'(bus.rd_size),      DW'(0));
        chk({tag, ".s_tready"}, DW'(bus.s_tready),     DW'(0));
        chk({tag, ".wr_valid"}, DW'(bus.buf_wr_valid), DW'(0));
        chk({tag, ".wr_addr"},  DW'(bus.buf_wr_addr),  DW'(0));
        chk({tag, ".wr_data"},  bus.buf_wr_data,       DW'(0));
    endtask

    // One instruction end to end; cycle 0 is the cycle ap_start is presented
    task automatic do_load(input string tag, input logic [3:0] bank, input logic [15:0] bstart,
                           input logic [15:0] blen, input int n_beats, input bit early_done,
                           input bit poke, input int rst_after);
        logic [DW-1:0]  beats[$];
        logic [NB-1:0]  exp_v[$];
        logic [BAW-1:0] exp_a[$];
        logic [DW-1:0]  exp_d[$];
        logic [NB-1:0]  obs_v[$];
        logic [BAW-1:0] obs_a[$];
        logic [DW-1:0]  obs_d[$];
        logic [AW-1:0]  off;
        logic [15:0]    dram, bytes;
        int k, sent, rs_cnt, rs_cyc, done_cnt, done_cyc, rd_cyc, h_cyc, exp_done, budget;
        bit hs, rd_sent;

        off   = {$urandom, $urandom};
        dram  = 16'($urandom);
        bytes = 16'(int'(blen) * 64);
        for (int i = 0; i < n_beats; i++) beats.push_back(rand_word());
        // Reference: the first beat_len beats land at consecutive wrapped addresses of the chosen bank
        for (int i = 0; i < int'(blen); i++) begin
            if (32'(bank) < NB) begin
                exp_v.push_back(NB'(1) << bank);
                exp_a.push_back(BAW'((int'(bstart) + i) % DEPTH));
                exp_d.push_back(beats[i]);
            end
        end

        ctrl_addr_offset = off;
        ctrl_instruction = make_inst(bank, bstart, blen, dram, bytes);
        ap_start = 1'b1;
        k = 0; sent = 0; rs_cnt = 0; rs_cyc = -1; done_cnt = 0; done_cyc = -1;
        rd_cyc = -1; h_cyc = -1; hs = 1'b0; rd_sent = 1'b0;
        budget = 200 + 4 * n_beats;

        while (k < budget && !(done_cnt > 0 && k >= done_cyc + 3)) begin
            @(posedge kernel_clk); #1;
            k++;
            if (hs) begin
                sent++;
                if (sent == int'(blen)) h_cyc = k - 1;
            end
            bus.rd_done = 1'b0;
            if (k == 1) ap_start = 1'b0;
            if (poke && k == 4) begin
                ap_start = 1'b1;
                ctrl_instruction = make_inst(4'd0, 16'd0, 16'd3, 16'd0, 16'd192);
            end
            if (poke && k == 5) ap_start = 1'b0;

            if (bus.rd_start) begin
                rs_cnt++;
                if (rs_cyc < 0) begin
                    rs_cyc = k;
                    chk({tag, ".rd_addr"}, DW'(bus.rd_addr), DW'(off + AW'(dram)));
                    chk({tag, ".rd_size"}, DW'(bus.rd_size), DW'(SW'(bytes)));
                end
            end
            if (bus.buf_wr_valid != '0) begin
                obs_v.push_back(bus.buf_wr_valid);
                obs_a.push_back(bus.buf_wr_addr);
                obs_d.push_back(bus.buf_wr_data);
            end
            if (ap_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end

            if (rst_after > 0 && sent == rst_after) begin
                kernel_rst_n = 1'b0;
                #1;
                chk_idle_outputs({tag, ".async"});
                bus.s_tvalid = 1'b0;
                bus.s_tlast  = 1'b0;
                bus.rd_done  = 1'b0;
                @(posedge kernel_clk); #1;
                kernel_rst_n = 1'b1;
                return;
            end

            if (rs_cyc >= 0 && k > rs_cyc) begin
                if (!rd_sent && ((early_done && sent == n_beats - 1) || (!early_done && sent == n_beats))) begin
                    bus.rd_done = 1'b1;
                    rd_sent = 1'b1;
                    rd_cyc = k;
                end
                if (sent < n_beats) begin
                    bus.s_tvalid = ($urandom_range(0, 3) != 0);
                    bus.s_tdata  = beats[sent];
                    bus.s_tlast  = (sent == n_beats - 1);
                end else begin
                    bus.s_tvalid = 1'b0;
                    bus.s_tlast  = 1'b0;
                end
            end
            hs = bus.s_tvalid && bus.s_tready;
        end

        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.rd_done  = 1'b0;

        if (blen == 16'd0) exp_done = 2;
        else exp_done = (h_cyc + 2 > rd_cyc + 1) ? h_cyc + 2 : rd_cyc + 1;

        chk({tag, ".rd_start_cnt"}, DW'(rs_cnt), DW'((blen == 16'd0) ? 0 : 1));
        if (blen != 16'd0) chk({tag, ".rd_start_cyc"}, DW'(rs_cyc), DW'(2));
        chk({tag, ".done_cnt"}, DW'(done_cnt), DW'(1));
        chk({tag, ".done_cyc"}, DW'(done_cyc), DW'(exp_done));
        chk({tag, ".n_writes"}, DW'(obs_v.size()), DW'(exp_v.size()));
        for (int i = 0; i < exp_v.size(); i++) begin
            if (i < obs_v.size()) begin
                chk($sformatf("%s.wr%0d.valid", tag, i), DW'(obs_v[i]), DW'(exp_v[i]));
                chk($sformatf("%s.wr%0d.addr", tag, i),  DW'(obs_a[i]), DW'(exp_a[i]));
                chk($sformatf("%s.wr%0d.data", tag, i),  obs_d[i],      exp_d[i]);
            end
        end
        chk({tag, ".busy_end"}, DW'(busy), DW'(0));
`ifdef BIAS_BANK_LOADER_CHECK_EN
        begin
            logic [1:0] exp_code;
            if (32'(bank) >= NB)             exp_code = 2'b01;
            else if (n_beats < int'(blen))   exp_code = 2'b10;
            else if (n_beats > int'(blen))   exp_code = 2'b11;
            else                             exp_code = 2'b00;
            chk({tag, ".err"},      DW'(err),      DW'(exp_code != 2'b00));
            chk({tag, ".err_code"}, DW'(err_code), DW'(exp_code));
        end
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        kernel_rst_n     = 1'b0;
        ap_start         = 1'b0;
        ctrl_addr_offset = '0;
        ctrl_instruction = '0;
        bus.rd_done  = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.s_tdata  = '0;
        repeat (3) @(posedge kernel_clk);
        #1;
        chk_idle_outputs("reset");
        kernel_rst_n = 1'b1;
        @(posedge kernel_clk); #1;

        do_load("basic",       4'd2, 16'd10,    16'd4,   4,   1'b0, 1'b0, 0);
        do_load("wrap",        4'd1, 16'd510,   16'd4,   4,   1'b0, 1'b0, 0);
        do_load("wrap_hi",     4'd3, 16'hFFFE,  16'd3,   3,   1'b0, 1'b0, 0);
        do_load("zero_len",    4'd0, 16'd5,     16'd0,   0,   1'b0, 1'b0, 0);
        do_load("drain",       4'd0, 16'd100,   16'd4,   6,   1'b0, 1'b0, 0);
        do_load("early_done",  4'd3, 16'd20,    16'd4,   4,   1'b1, 1'b0, 0);
        do_load("bad_bank",    4'd7, 16'd7,     16'd3,   3,   1'b0, 1'b0, 0);
        do_load("reset_mid",   4'd2, 16'd40,    16'd8,   8,   1'b0, 1'b0, 2);
        do_load("after_reset", 4'd2, 16'd40,    16'd5,   5,   1'b0, 1'b0, 0);
        do_load("busy_poke",   4'd1, 16'd300,   16'd6,   6,   1'b0, 1'b1, 0);
        do_load("overwrite",   4'd0, 16'd508,   16'd515, 515, 1'b0, 1'b0, 0);

        for (int t = 0; t < 8; t++) begin
            logic [3:0]  rb;
            logic [15:0] rs, rl;
            int          rn;
            bit          re;
            rb = 4'($urandom_range(0, 5));
            rs = 16'($urandom);
            rl = 16'($urandom_range(1, 10));
            rn = int'(rl) + int'($urandom_range(0, 2));
            re = (rn == int'(rl)) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_load($sformatf("rand%0d", t), rb, rs, rl, rn, re, 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
